// File: rtl/z90_alu_pkg.sv
// Z90 ALU flag constants, op encodings and the 16-bit execute function shared by
// the arbitrated ALU front-end.
package z90_alu_pkg;

  localparam logic [7:0] Z90_F_Z = 8'h01;
  localparam logic [7:0] Z90_F_S = 8'h02;
  localparam logic [7:0] Z90_F_C = 8'h04;
  localparam logic [7:0] Z90_F_V = 8'h08;

  typedef enum logic [2:0] {
    Z90_ALU_ADD = 3'd0,
    Z90_ALU_SUB = 3'd1,
    Z90_ALU_AND = 3'd2,
    Z90_ALU_OR  = 3'd3,
    Z90_ALU_XOR = 3'd4
  } z90_alu_op_e;

  typedef struct packed {
    logic [15:0] res;
    logic [7:0]  f;
    logic        err;
  } z90_alu16_t;

  // Undefined encodings return an all-zero result with err set; Z is deliberately not raised.
  function automatic z90_alu16_t z90_alu16_exec(input logic [2:0]  op,
                                                input logic [15:0] a,
                                                input logic [15:0] b);
    z90_alu16_t r;
    logic [16:0] wide;
    r    = '0;
    wide = '0;
    case (op)
      Z90_ALU_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        r.res = wide[15:0];
        if (wide[16]) r.f = r.f | Z90_F_C;
        if ((a[15] == b[15]) && (r.res[15] != a[15])) r.f = r.f | Z90_F_V;
      end
      Z90_ALU_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        r.res = wide[15:0];
        if (wide[16]) r.f = r.f | Z90_F_C;
        if ((a[15] != b[15]) && (r.res[15] != a[15])) r.f = r.f | Z90_F_V;
      end
      Z90_ALU_AND: r.res = a & b;
      Z90_ALU_OR:  r.res = a | b;
      Z90_ALU_XOR: r.res = a ^ b;
      default:     r.err = 1'b1;
    endcase
    if (!r.err) begin
      if (r.res == 16'h0000) r.f = r.f | Z90_F_Z;
      if (r.res[15])         r.f = r.f | Z90_F_S;
    end
    return r;
  endfunction

endpackage

// File: rtl/z90_rr_arb.sv
// Round-robin arbiter: search starts at the rotating pointer, pointer moves past
// the winner only on an actual grant.
module z90_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = IW'(j);
        gnt[j]  = en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/z90_alu16_arb.sv
// Shares one Z90 16-bit ALU between NREQ requesters: round-robin grant,
// one-entry registered result with valid/ready toward the consumer.
module z90_alu16_arb
  import z90_alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0][2:0]   req_op,
  input  logic [NREQ-1:0][15:0]  req_a,
  input  logic [NREQ-1:0][15:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_res,
  output logic [7:0]             rsp_f,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_err
);

  logic            slot_free;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            xfer;
  z90_alu16_t      exec_r;

  // Gate with rst so nothing is offered while reset is held, even if rsp_ready is high.
  assign slot_free = !rst && (!rsp_valid || rsp_ready);

  z90_rr_arb #(.N(NREQ), .IW(IDW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (slot_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign exec_r    = z90_alu16_exec(req_op[gnt_idx], req_a[gnt_idx], req_b[gnt_idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_f     <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_res   <= exec_r.res;
      rsp_f     <= exec_r.f;
      rsp_id    <= gnt_idx;
      rsp_err   <= exec_r.err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z90_alu16_arb.sv
// Directed self-checking bench for z90_alu16_arb with two requesters.
module tb_z90_alu16_arb;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][2:0]  req_op = '0;
  logic [1:0][15:0] req_a = '0;
  logic [1:0][15:0] req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [15:0]      rsp_res;
  logic [7:0]       rsp_f;
  logic [0:0]       rsp_id;
  logic             rsp_err;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [7:0]  f;
  } vec_t;

  always #5 clk = ~clk;

  z90_alu16_arb #(.NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_f     (rsp_f),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  // Drive a single request from requester r for one cycle with the consumer ready.
  task automatic issue(input int r, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    req_op[r]    = op;
    req_a[r]     = a;
    req_b[r]     = b;
    rsp_ready    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = '0;
    exp_ptr   = (r + 1) % 2;
  endtask

  task automatic test_reset;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #2;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++;
    if ({rsp_valid, rsp_res, rsp_f, rsp_id, rsp_err} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b res=%h f=%h id=%0d err=%b exp all 0", rsp_valid, rsp_res, rsp_f, rsp_id, rsp_err);
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got=%b exp=0", rsp_valid); end
    exp_ptr = 0;
  endtask

  task automatic test_arith;
    vec_t v[4];
    v[0] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 8'h0A};
    v[1] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 8'h05};
    v[2] = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 8'h06};
    v[3] = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 8'h08};
    for (int i = 0; i < 4; i++) begin
      issue(0, v[i].op, v[i].a, v[i].b);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_res !== v[i].res || rsp_f !== v[i].f || rsp_err !== 1'b0 || rsp_id !== 1'b0) begin
        errors++;
        $display("FAIL arith_%0d got v=%b res=%h f=%h err=%b id=%0d exp v=1 res=%h f=%h err=0 id=0",
                 i, rsp_valid, rsp_res, rsp_f, rsp_err, rsp_id, v[i].res, v[i].f);
      end
    end
  endtask

  task automatic test_logic;
    vec_t v[4];
    v[0] = '{3'd2, 16'h00FF, 16'hFF00, 16'h0000, 8'h01};
    v[1] = '{3'd4, 16'h1234, 16'h1234, 16'h0000, 8'h01};
    v[2] = '{3'd3, 16'h1200, 16'h0034, 16'h1234, 8'h00};
    v[3] = '{3'd4, 16'h8000, 16'h0001, 16'h8001, 8'h02};
    for (int i = 0; i < 4; i++) begin
      issue(i % 2, v[i].op, v[i].a, v[i].b);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_res !== v[i].res || rsp_f !== v[i].f || rsp_id !== 1'(i % 2)) begin
        errors++;
        $display("FAIL logic_%0d got v=%b res=%h f=%h id=%0d exp v=1 res=%h f=%h id=%0d",
                 i, rsp_valid, rsp_res, rsp_f, rsp_id, v[i].res, v[i].f, i % 2);
      end
    end
  endtask

  task automatic test_invalid;
    issue(1, 3'd7, 16'h1234, 16'h5678);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_res !== 16'h0000 || rsp_f !== 8'h00 || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL invalid_op got v=%b err=%b res=%h f=%h id=%0d exp v=1 err=1 res=0000 f=00 id=1",
               rsp_valid, rsp_err, rsp_res, rsp_f, rsp_id);
    end
    issue(0, 3'd0, 16'h0001, 16'h0001);
    checks++;
    if (rsp_err !== 1'b0 || rsp_res !== 16'h0002 || rsp_f !== 8'h00 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL invalid_clear got err=%b res=%h f=%h id=%0d exp err=0 res=0002 f=00 id=0",
               rsp_err, rsp_res, rsp_f, rsp_id);
    end
  endtask

  task automatic test_fairness;
    logic [15:0] exp_res;
    @(negedge clk);
    req_op[0] = 3'd0; req_a[0] = 16'h0001; req_b[0] = 16'h0002;
    req_op[1] = 3'd1; req_a[1] = 16'h0005; req_b[1] = 16'h0003;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (req_ready !== 2'(1 << exp_ptr)) begin
        errors++;
        $display("FAIL fair_grant_%0d got=%b exp=%b", i, req_ready, 2'(1 << exp_ptr));
      end
      @(posedge clk);
      #1;
      exp_res = (exp_ptr == 0) ? 16'h0003 : 16'h0002;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(exp_ptr) || rsp_res !== exp_res) begin
        errors++;
        $display("FAIL fair_rsp_%0d got v=%b id=%0d res=%h exp v=1 id=%0d res=%h",
                 i, rsp_valid, rsp_id, rsp_res, exp_ptr, exp_res);
      end
      exp_ptr = 1 - exp_ptr;
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    issue(0, 3'd0, 16'h0100, 16'h0001);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_op[0] = 3'd2; req_a[0] = 16'hFFFF; req_b[0] = 16'h0F0F;
    req_op[1] = 3'd4; req_a[1] = 16'h00F0; req_b[1] = 16'h000F;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready got=%b exp=00", req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_res !== 16'h0101 || rsp_f !== 8'h00 || rsp_id !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b res=%h f=%h id=%0d exp v=1 res=0101 f=00 id=0",
                 i, rsp_valid, rsp_res, rsp_f, rsp_id);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_regrant got=%b exp=10", req_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 16'h00FF || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL bp_reload got v=%b res=%h id=%0d exp v=1 res=00FF id=1", rsp_valid, rsp_res, rsp_id);
    end
    @(negedge clk);
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 16'h0F0F || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL bp_next got v=%b res=%h id=%0d exp v=1 res=0F0F id=0", rsp_valid, rsp_res, rsp_id);
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_res !== 16'h0F0F) begin
      errors++;
      $display("FAIL bp_drain got v=%b res=%h exp v=0 res=0F0F", rsp_valid, rsp_res);
    end
    exp_ptr = 1;
  endtask

  task automatic test_single;
    @(negedge clk);
    req_op[1] = 3'd0; req_a[1] = 16'h0010; req_b[1] = 16'h0020;
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req_ready !== 2'b10) begin errors++; $display("FAIL single_grant_%0d got=%b exp=10", i, req_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 16'h0030) begin
        errors++;
        $display("FAIL single_rsp_%0d got v=%b id=%0d res=%h exp v=1 id=1 res=0030", i, rsp_valid, rsp_id, rsp_res);
      end
      @(negedge clk);
    end
    req_valid = '0;
    exp_ptr = 0;
  endtask

  task automatic test_reset_mid;
    issue(0, 3'd0, 16'h0003, 16'h0004);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_res, rsp_f, rsp_id, rsp_err} !== 27'd0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset got v=%b res=%h f=%h id=%0d err=%b rdy=%b exp all 0",
               rsp_valid, rsp_res, rsp_f, rsp_id, rsp_err, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_stale got v=%b exp=0", rsp_valid); end
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_reset_ptr got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_invalid();
    test_fairness();
    test_backpressure();
    test_single();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
